// File: rtl/right_shift_reg.sv
// DW-bit right-shift register: parallel load, serial MSB insert, or hold each clock.
// Asynchronous active-low reset clears the register immediately.
module right_shift_reg #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] data,
  input  logic          data_h,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_d;
  logic [DW-1:0] q_q;

  // Load takes priority over shift; q[0] falls off the end on a shift.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = data;
    end else if (en) begin
      q_d = {data_h, q_q[DW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_right_shift_reg.sv
// Directed + randomized bench for right_shift_reg against an arithmetic reference model.
module tb_right_shift_reg;

  localparam int unsigned DW = 4;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic          data_h;
  logic [DW-1:0] q;

  int unsigned   n_pass;
  int unsigned   n_total;
  int unsigned   model;

  right_shift_reg #(.DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (en),
    .data   (data),
    .data_h (data_h),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: load replaces, shift is integer halving plus data_h weighted at the MSB.
  task automatic model_edge(input logic l, input logic e, input logic [DW-1:0] d,
                            input logic dh);
    if (!rst_n) model = 0;
    else if (l) model = int'(d);
    else if (e) model = (model / 2) + (int'(dh) * (1 << (DW - 1)));
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic l, input logic e, input logic [DW-1:0] d, input logic dh);
    load   = l;
    en     = e;
    data   = d;
    data_h = dh;
    @(posedge clk);
    model_edge(l, e, d, dh);
    #1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          rh;
    logic          rl;
    n_pass  = 0;
    n_total = 0;
    model   = 0;
    rst_n   = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    data    = '0;
    data_h  = 1'b0;

    #2;
    check("reset_state", q, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Async reset between edges with q = A
    step(1'b1, 1'b0, 4'hA, 1'b0);
    check("load_a", q, 4'hA);
    #2;
    rst_n = 1'b0;
    model = 0;
    #1;
    check("async_clear", q, 4'h0);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    check("reset_hold", q, 4'h0);
    rst_n = 1'b1;

    // Load then hold with changing data
    step(1'b1, 1'b0, 4'h9, 1'b0);
    check("load_9", q, 4'h9);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, DW'($urandom), 1'($urandom));
      check("hold_9", q, 4'h9);
    end

    // Load 1011 then shift in 1,0,0,1
    step(1'b1, 1'b0, 4'b1011, 1'b0);
    check("load_b", q, 4'b1011);
    step(1'b0, 1'b1, 4'h0, 1'b1);
    check("shift1", q, 4'b1101);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    check("shift2", q, 4'b0110);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    check("shift3", q, 4'b0011);
    step(1'b0, 1'b1, 4'h0, 1'b1);
    check("shift4", q, 4'b1001);
    check("shift4_model", q, DW'(model));

    // Load wins over en
    step(1'b1, 1'b1, 4'h5, 1'b1);
    check("load_priority", q, 4'h5);
    step(1'b0, 1'b1, 4'hF, 1'b0);
    check("shift_after_load", q, 4'h2);

    // Randomized shifting with periodic loads
    for (int i = 0; i < 32; i++) begin
      rd = DW'($urandom);
      rh = 1'($urandom);
      rl = (i % 8 == 0);
      step(rl, 1'b1, rd, rh);
      check("rand_model", q, DW'(model));
    end

    // Randomized mix of load/en/hold
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));
      check("rand_mix", q, DW'(model));
    end

    // Reset during shifting, then resume from zero
    step(1'b1, 1'b0, 4'hF, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b1);
    check("pre_reset_shift", q, 4'hF);
    #2;
    rst_n = 1'b0;
    model = 0;
    #1;
    check("mid_shift_reset", q, 4'h0);
    step(1'b0, 1'b1, 4'h0, 1'b1);
    check("reset_overrides_en", q, 4'h0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 4'h0, 1'b1);
    check("resume_shift", q, 4'b1000);
    check("resume_model", q, DW'(model));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
